// File: rtl/keypad_scanner_pkg.sv
// Shared keypad constants: paddle key codes, the 4x4 layout and a
// (valid, code) candidate type used between the scanner and the debouncer.
// Ports: none (package).
package keypad_scanner_pkg;

  // Codes the game logic treats as paddle movement.
  localparam logic [3:0] KEY_UP   = 4'd2;
  localparam logic [3:0] KEY_DOWN = 4'd8;

  // Non-digit keys.
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef struct packed {
    logic       vld;
    logic [3:0] code;
  } key_cand_t;

  // Keypad layout, row-major:
  //   row0: 1 2 3 A / row1: 4 5 6 B / row2: 7 8 9 C / row3: * 0 # D
  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_A;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_B;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'd0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  // Lowest-index low (pressed) column; 0 when none is low.
  function automatic logic [1:0] first_low(input logic [3:0] col_n);
    logic [1:0] idx;
    if (!col_n[0])      idx = 2'd0;
    else if (!col_n[1]) idx = 2'd1;
    else if (!col_n[2]) idx = 2'd2;
    else if (!col_n[3]) idx = 2'd3;
    else                idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_debouncer.sv
// Per-frame debouncer: commits a keypad candidate once it has been seen in
// DEBOUNCE_SCANS consecutive identical frames.
// Ports: clk_i/rst_i (async active-high), frame_done_i + cand_vld_i/cand_code_i
//        in; key_code_o, key_valid_o, key_pressed_o (one-cycle pulse) out.
module key_debouncer
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_done_i,
  input  logic       cand_vld_i,
  input  logic [3:0] cand_code_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_pressed_o
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  key_cand_t     cand_n;
  key_cand_t     prev_q, prev_d;
  key_cand_t     out_q, out_d;
  logic [SW-1:0] stable_q, stable_d;
  logic          pressed_q, pressed_d;

  // An invalid candidate always carries code 0 so it compares equal to the
  // idle output state.
  always_comb begin
    cand_n.vld  = cand_vld_i;
    cand_n.code = cand_vld_i ? cand_code_i : 4'd0;
  end

  always_comb begin
    prev_d    = prev_q;
    stable_d  = stable_q;
    out_d     = out_q;
    pressed_d = 1'b0;
    if (frame_done_i) begin
      if (cand_n == prev_q) begin
        stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + 1'b1;
      end else begin
        stable_d = SW'(1);
      end
      prev_d = cand_n;
      // Only a real change of the visible state commits; a release commits
      // silently, a press or a held code change pulses.
      if (stable_d == STABLE_MAX && cand_n != out_q) begin
        out_d     = cand_n;
        pressed_d = cand_n.vld;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q    <= '0;
      out_q     <= '0;
      stable_q  <= '0;
      pressed_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      out_q     <= out_d;
      stable_q  <= stable_d;
      pressed_q <= pressed_d;
    end
  end

  assign key_code_o    = out_q.code;
  assign key_valid_o   = out_q.vld;
  assign key_pressed_o = pressed_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, synchronises the
// columns, picks the first pressed key per frame and debounces it.
// Ports: CLOCK_25, reset (async active-high), row (active-low drive),
//        col (active-low sense, async), key_code, key_valid, key_pressed.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    col_s1_q, col_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_idx_q, row_idx_d;
  key_cand_t     cand_q, cand_d;
  key_cand_t     row_hit, frame_cand;
  logic          sample_en, frame_done;

  // Columns idle high through the pull-ups, so the synchroniser resets to 1s.
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col;
      col_s2_q <= col_s1_q;
    end
  end

  always_comb begin
    // Sampling on the last dwell cycle leaves SCAN_DIV-1 cycles for the row
    // change to reach col_s2_q.
    sample_en   = (dwell_q == DWELL_LAST);
    frame_done  = sample_en && (row_idx_q == 2'd3);

    row_hit.vld  = ~&col_s2_q;
    row_hit.code = row_hit.vld ? key_at(row_idx_q, first_low(col_s2_q)) : 4'd0;

    // The first hit in scan order wins; later rows cannot override it.
    frame_cand = cand_q.vld ? cand_q : row_hit;

    dwell_d   = sample_en ? '0 : dwell_q + 1'b1;
    row_idx_d = sample_en ? row_idx_q + 2'd1 : row_idx_q;

    cand_d = cand_q;
    if (sample_en) begin
      cand_d = frame_done ? key_cand_t'('0) : frame_cand;
    end
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      dwell_q   <= '0;
      row_idx_q <= 2'd0;
      cand_q    <= '0;
    end else begin
      dwell_q   <= dwell_d;
      row_idx_q <= row_idx_d;
      cand_q    <= cand_d;
    end
  end

  assign row = ~(4'b0001 << row_idx_q);

  key_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .clk_i        (CLOCK_25),
    .rst_i        (reset),
    .frame_done_i (frame_done),
    .cand_vld_i   (frame_cand.vld),
    .cand_code_i  (frame_cand.code),
    .key_code_o   (key_code),
    .key_valid_o  (key_valid),
    .key_pressed_o(key_pressed)
  );

endmodule
